fifo_wr_ctrl: RTL



---
 rtl/fifo_wr_ctrl_pkg.sv | 23 ++
 rtl/fifo_wr_ctrl_ptr_sync.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared FIFO geometry and pointer encoding, used by both the write- and read-side controllers
// so that the two clock domains agree on the Gray code.
package fifo_wr_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RAM_SIZE   = 1 << DEF_ADDR_WIDTH;

    // Conversions work on zero-extended 32-bit values; callers cast back to pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module ptr_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write side of the router input-buffer async FIFO: upstream handshake, RAM write port,
// binary/Gray write pointer and full/occupancy from the synchronised read pointer.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RAM_SIZE   = DEF_RAM_SIZE
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr_bin_q;
    logic [PTR_W-1:0] wr_ptr_bin_d;
    logic [PTR_W-1:0] wr_ptr_gray_q;
    logic [PTR_W-1:0] wr_ptr_gray_d;
    logic [PTR_W-1:0] rd_sync2;
    logic [PTR_W-1:0] rd_full_gray;
    logic [PTR_W-1:0] rd_bin;
    logic             full_q;
    logic             full_d;
    logic             init_done_q;
    logic             xfer;

    ptr_sync #(
        .WIDTH (PTR_W)
    ) u_rd_sync (
        .clk_i   (wr_clk),
        .rst_n_i (rst_n),
        .d_i     (rd_ptr_gray),
        .q_o     (rd_sync2)
    );

    assign in_ready = init_done_q & ~full_q;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        wr_ptr_bin_d = wr_ptr_bin_q;
        if (xfer) begin
            wr_ptr_bin_d = wr_ptr_bin_q + PTR_W'(1);
        end
        wr_ptr_gray_d = PTR_W'(bin2gray(32'(wr_ptr_bin_d)));
        // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
        rd_full_gray  = {~rd_sync2[PTR_W-1 -: 2], rd_sync2[PTR_W-3:0]};
        full_d        = (wr_ptr_gray_d == rd_full_gray);
        rd_bin        = PTR_W'(gray2bin(32'(rd_sync2)));
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_bin_q  <= '0;
            wr_ptr_gray_q <= '0;
            full_q        <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            wr_ptr_bin_q  <= wr_ptr_bin_d;
            wr_ptr_gray_q <= wr_ptr_gray_d;
            full_q        <= full_d;
            init_done_q   <= 1'b1;
        end
    end

    assign wr_en       = xfer;
    assign wr_addr     = wr_ptr_bin_q[ADDR_WIDTH-1:0];
    assign wr_data     = in_data;
    assign wr_ptr_gray = wr_ptr_gray_q;
    assign full        = full_q;
    // Stale read pointer makes this an upper bound on the true occupancy.
    assign wr_count    = wr_ptr_bin_q - rd_bin;
    assign almost_full = (wr_count >= PTR_W'(RAM_SIZE - 1));

endmodule
